instr_fetch_unit: RTL and testbench

- Multi-cycle instruction fetch front end. It is the producer of the OpCode/Funct fields that the Control decoder consumes.
- Holds the PC and fetches words from instruction memory over a req/ack handshake. It latches each word in an instruction register and presents the decoded fields, qualified by instr_valid.
- When the downstream stage consumes an instruction, it updates the PC using the Jump and resolved-branch signals.

---
 rtl/instr_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Multi-cycle instruction fetch front end. Holds the PC, fetches one word at a
// time from instruction memory over a req/ack handshake, latches it in the
// instruction register (IR) and presents the decoded MIPS-style fields,
// qualified by instr_valid. When the downstream stage consumes the instruction
// (instr_valid=1, stall=0) the PC advances to PC+4, the branch target or the
// jump target, and the next fetch starts.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   imem_req          fetch request (high in FETCH only)
//   imem_addr         fetch address (= pc)
//   imem_ack          memory returns imem_rdata this cycle
//   imem_rdata        instruction word
//   stall             downstream cannot consume the presented instruction
//   Jump, take_branch PC-redirect controls, sampled on the consume cycle only
//   instr_valid       decoded fields are valid
//   OpCode .. Imm16   fields of IR
//   PC, PCPlus4       address of the instruction in IR and that address + 4
//   instr_count       number of consumed instructions (wraps)
//   fetch_fault       sticky: a fetch went TIMEOUT cycles without ack
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 16  // 2..255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        Jump,
  input  logic        take_branch,
  output logic        instr_valid,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [4:0]  Shamt,
  output logic [15:0] Imm16,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] instr_count,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  // Last counter value of a fetch; the request is therefore high TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] count_q, count_d;
  logic [7:0]  tmo_q, tmo_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;

  assign pc_plus4      = pc_q + 32'd4;
  assign jump_target   = {pc_plus4[31:28], ir_q[25:0], 2'b00};
  assign branch_target = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      count_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a hold default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    count_d = count_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
        tmo_d   = '0;
      end

      S_FETCH: begin
        // An ack on the last counted cycle still wins over the timeout.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_ISSUE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      S_ISSUE: begin
        if (!stall) begin
          count_d = count_q + 32'd1;
          tmo_d   = '0;
          state_d = S_FETCH;
          if (Jump)             pc_d = jump_target;
          else if (take_branch) pc_d = branch_target;
          else                  pc_d = pc_plus4;
        end
      end

      S_FAULT: begin
        // Terminal until reset; imem_ack is ignored here.
        state_d = S_FAULT;
      end

      default: state_d = S_RESET;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (Moore: state and registers only)
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req    = (state_q == S_FETCH);
    instr_valid = (state_q == S_ISSUE);
    fetch_fault = (state_q == S_FAULT);
  end

  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign instr_count = count_q;

  assign OpCode = ir_q[31:26];
  assign Rs     = ir_q[25:21];
  assign Rt     = ir_q[20:16];
  assign Rd     = ir_q[15:11];
  assign Shamt  = ir_q[10:6];
  assign Funct  = ir_q[5:0];
  assign Imm16  = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        Jump;
  logic        take_branch;
  logic        instr_valid;
  logic [5:0]  OpCode;
  logic [5:0]  Funct;
  logic [4:0]  Rs;
  logic [4:0]  Rt;
  logic [4:0]  Rd;
  logic [4:0]  Shamt;
  logic [15:0] Imm16;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] instr_count;
  logic        fetch_fault;

  instr_fetch_unit #(.RESET_PC(32'h0000_3000), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .Jump       (Jump),
    .take_branch(take_branch),
    .instr_valid(instr_valid),
    .OpCode     (OpCode),
    .Funct      (Funct),
    .Rs         (Rs),
    .Rt         (Rt),
    .Rd         (Rd),
    .Shamt      (Shamt),
    .Imm16      (Imm16),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .instr_count(instr_count),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // One directed fetch: word, its address, ack delay, stall cycles, redirect
  // controls, hand-computed next fetch address and decoded fields.
  typedef struct {
    logic [31:0] rdata;
    logic [31:0] pc;
    int          delay;
    int          stall_n;
    logic        jump;
    logic        tb;
    logic [31:0] next;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [5:0]  funct;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [5:0]  funct;
    logic [31:0] cnt;
  } exp_t;

  vec_t        vecs[7];
  exp_t        issue_q[$];
  logic [31:0] addr_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: a rising imem_req starts a fetch whose address is scoreboarded;
  // a rising instr_valid presents an instruction whose fields are scoreboarded.
  // ---------------------------------------------------------------------------
  logic prev_req   = 1'b0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_req   <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      if (imem_req && !prev_req) begin
        if (addr_q.size() == 0) begin
          check("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
        end else begin
          check("fetch_addr", imem_addr, addr_q.pop_front());
        end
      end
      if (instr_valid && !prev_valid) begin
        if (issue_q.size() == 0) begin
          check("unexpected_issue", PC, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = issue_q.pop_front();
          check("issue_pc",      PC,          e.pc);
          check("issue_pcplus4", PCPlus4,     e.pc + 32'd4);
          check("issue_opcode",  32'(OpCode), 32'(e.op));
          check("issue_rs",      32'(Rs),     32'(e.rs));
          check("issue_rt",      32'(Rt),     32'(e.rt));
          check("issue_rd",      32'(Rd),     32'(e.rd));
          check("issue_imm16",   32'(Imm16),  32'(e.imm));
          check("issue_funct",   32'(Funct),  32'(e.funct));
          check("issue_count",   instr_count, e.cnt);
        end
      end
      prev_req   <= imem_req;
      prev_valid <= instr_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: serve one fetch as instruction memory, then stall and consume.
  // Entered at a negedge; leaves at the negedge after the consume edge.
  // ---------------------------------------------------------------------------
  task automatic run_vec(input vec_t v, input int idx);
    int   waited;
    int   req_cycles;
    exp_t e;
    waited = 0;
    while (!imem_req && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("req_seen", 32'(imem_req), 32'd1);

    req_cycles = 0;
    for (int c = 0; c < v.delay; c++) begin
      if (imem_req) req_cycles++;
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    if (imem_req) req_cycles++;
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    e = '{pc: v.pc, op: v.op, rs: v.rs, rt: v.rt, rd: v.rd, imm: v.imm,
          funct: v.funct, cnt: 32'(idx)};
    issue_q.push_back(e);
    // Redirect controls are don't-care while stalled; drive them active.
    stall       = (v.stall_n > 0);
    Jump        = 1'b1;
    take_branch = 1'b1;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("req_cycles", 32'(req_cycles), 32'(v.delay + 1));

    for (int s = 0; s < v.stall_n; s++) begin
      if (s == v.stall_n - 1) stall = 1'b1;
      @(negedge clk);
      check("stall_valid",  32'(instr_valid), 32'd1);
      check("stall_req",    32'(imem_req),    32'd0);
      check("stall_pc",     PC,               v.pc);
      check("stall_opcode", 32'(OpCode),      32'(v.op));
      check("stall_count",  instr_count,      32'(idx));
    end

    stall       = 1'b0;
    Jump        = v.jump;
    take_branch = v.tb;
    addr_q.push_back(v.next);
    @(negedge clk);
    Jump        = 1'b0;
    take_branch = 1'b0;
    check("consume_count", instr_count, 32'(idx + 1));
  endtask

  initial begin
    //        rdata         pc            dly stl jmp tb  next          op     rs  rt  rd  imm       funct
    vecs[0] = '{32'h24080005, 32'h0000_3000, 0, 0, 1'b0, 1'b0, 32'h0000_3004, 6'h09, 5'd0, 5'd8, 5'd0,  16'h0005, 6'h05};
    vecs[1] = '{32'h24080005, 32'h0000_3004, 3, 4, 1'b0, 1'b0, 32'h0000_3008, 6'h09, 5'd0, 5'd8, 5'd0,  16'h0005, 6'h05};
    vecs[2] = '{32'h1000FFFE, 32'h0000_3008, 0, 0, 1'b0, 1'b1, 32'h0000_3004, 6'h04, 5'd0, 5'd0, 5'd31, 16'hFFFE, 6'h3E};
    vecs[3] = '{32'h00851020, 32'h0000_3004, 1, 0, 1'b0, 1'b0, 32'h0000_3008, 6'h00, 5'd4, 5'd5, 5'd2,  16'h1020, 6'h20};
    vecs[4] = '{32'h1000FFFE, 32'h0000_3008, 0, 1, 1'b0, 1'b0, 32'h0000_300C, 6'h04, 5'd0, 5'd0, 5'd31, 16'hFFFE, 6'h3E};
    vecs[5] = '{32'h8C430010, 32'h0000_300C, 2, 0, 1'b0, 1'b0, 32'h0000_3010, 6'h23, 5'd2, 5'd3, 5'd0,  16'h0010, 6'h10};
    vecs[6] = '{32'h08000C10, 32'h0000_3010, 0, 0, 1'b1, 1'b1, 32'h0000_3040, 6'h02, 5'd0, 5'd0, 5'd1,  16'h0C10, 6'h10};
  end

  initial begin : stim
    int cycles;
    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
    Jump        = 1'b0;
    take_branch = 1'b0;
    addr_q.push_back(32'h0000_3000);

    // Reset
    @(negedge clk);
    @(negedge clk);
    check("rst_req",    32'(imem_req),    32'd0);
    check("rst_valid",  32'(instr_valid), 32'd0);
    check("rst_count",  instr_count,      32'd0);
    check("rst_fault",  32'(fetch_fault), 32'd0);
    check("rst_opcode", 32'(OpCode),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("release_req",  32'(imem_req), 32'd1);
    check("release_addr", imem_addr,     32'h0000_3000);

    // Directed fetch / stall / branch / jump sequence
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Timeout: fetch at 0x3040 with no ack
    cycles = 0;
    while (imem_req && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    check("timeout_req_cycles", 32'(cycles),      32'd16);
    check("timeout_fault",      32'(fetch_fault), 32'd1);
    check("timeout_req_low",    32'(imem_req),    32'd0);

    // Late ack in FAULT is ignored
    imem_ack   = 1'b1;
    imem_rdata = 32'h2408_0005;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_fault", 32'(fetch_fault), 32'd1);
    check("late_ack_req",   32'(imem_req),    32'd0);
    check("late_ack_valid", 32'(instr_valid), 32'd0);
    check("fault_count",    instr_count,      32'd7);

    // Reset clears the fault and fetching restarts at RESET_PC
    addr_q.push_back(32'h0000_3000);
    rst = 1'b1;
    @(negedge clk);
    check("rerst_fault", 32'(fetch_fault), 32'd0);
    check("rerst_count", instr_count,      32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("restart_req",  32'(imem_req), 32'd1);
    check("restart_addr", imem_addr,     32'h0000_3000);
    @(negedge clk);

    check("addr_q_drained",  32'(addr_q.size()),  32'd0);
    check("issue_q_drained", 32'(issue_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
